// File: rtl/udc_bus_sequencer_pkg.sv
// Shared types and constants for the updown-counter chip-select bus sequencer.
package udc_pkg;

   // Native data width of the counter bus; request structs carry this many bits.
   localparam int UDC_DATA_W = 8;

   // Counter register map, {A1,A0}
   localparam logic [1:0] ADDR_LOAD = 2'd0;
   localparam logic [1:0] ADDR_CTRL = 2'd1;
   localparam logic [1:0] ADDR_STAT = 2'd2;
   localparam logic [1:0] ADDR_CNT  = 2'd3;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      STROBE,
      HOLD,
      START
   } seq_state_t;

   typedef struct packed {
      logic                  wr;
      logic [1:0]            addr;
      logic [UDC_DATA_W-1:0] wdata;
   } req_t;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/udc_bus_sequencer_if.sv
// Host/self-test request ports, response, start control and counter bus pins.
interface udc_bus_sequencer_if #(
   parameter int DATA_W = 8
);
   logic              req0_valid;
   logic              req0_ready;
   logic              req0_wr;
   logic [1:0]        req0_addr;
   logic [DATA_W-1:0] req0_wdata;

   logic              req1_valid;
   logic              req1_ready;
   logic              req1_wr;
   logic [1:0]        req1_addr;
   logic [DATA_W-1:0] req1_wdata;

   logic              start_req;

   logic              rsp_valid;
   logic              rsp_id;
   logic [DATA_W-1:0] rsp_rdata;

   logic [DATA_W-1:0] bus_rdata;
   logic              ncs;
   logic              nrd;
   logic              nwr;
   logic              A0;
   logic              A1;
   logic [DATA_W-1:0] din;
   logic              start_in;

   // Sequencer side: owns the strobes, readies and responses.
   modport master (
      input  req0_valid, req0_wr, req0_addr, req0_wdata,
      input  req1_valid, req1_wr, req1_addr, req1_wdata,
      input  start_req, bus_rdata,
      output req0_ready, req1_ready,
      output rsp_valid, rsp_id, rsp_rdata,
      output ncs, nrd, nwr, A0, A1, din, start_in
   );

   // Requester/counter side.
   modport slave (
      output req0_valid, req0_wr, req0_addr, req0_wdata,
      output req1_valid, req1_wr, req1_addr, req1_wdata,
      output start_req, bus_rdata,
      input  req0_ready, req1_ready,
      input  rsp_valid, rsp_id, rsp_rdata,
      input  ncs, nrd, nwr, A0, A1, din, start_in
   );

endinterface

// File: rtl/udc_bus_sequencer_rr_arb2.sv
// Two-way round-robin arbiter; the requester not served last wins a tie.
module udc_rr_arb2 (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] valid,
   input  logic       en,
   output logic [1:0] ready,
   output logic       grant
);

   logic rr_last;

   // Prefer the requester that was not served last; fall back to the other.
   always_comb begin
      grant = valid[~rr_last] ? ~rr_last : rr_last;
      ready = 2'b00;
      if (en && valid[grant]) ready[grant] = 1'b1;
   end

   // Remember who was served; reset to 1 so requester 0 wins first.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)       rr_last <= 1'b1;
      else if (|ready) rr_last <= grant;
   end

endmodule

// File: rtl/udc_bus_sequencer.sv
// Chip-select bus sequencer for the updown counter: arbitrates two requesters,
// times ncs/nrd/nwr/address/data phases, returns responses, pulses start_in.
module udc_bus_sequencer
   import udc_pkg::*;
#(
   parameter int DATA_W     = UDC_DATA_W,
   parameter int SETUP_CYC  = 1,
   parameter int STROBE_CYC = 2,
   parameter int HOLD_CYC   = 1,
   parameter int START_W    = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   udc_bus_sequencer_if.master  bus
);

   // One down-counter times every phase, so it is sized for the longest one.
   localparam int MAX_CYC = max2(max2(SETUP_CYC, STROBE_CYC), max2(HOLD_CYC, START_W));
   localparam int CNT_W   = $clog2(MAX_CYC + 1);

   seq_state_t       state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic             start_pend;
   logic             go_start;
   logic             arb_en;
   logic [1:0]       arb_ready;
   logic             arb_grant;
   logic             accept;
   req_t             req_sel;
   req_t             lat;
   logic             lat_id;
   logic             rsp_valid_q;
   logic             rsp_id_q;
   logic [DATA_W-1:0] rsp_rdata_q;

   // A start request, pending or arriving now, beats any bus request in IDLE.
   assign go_start = (state == IDLE) && (start_pend || bus.start_req);
   assign arb_en   = (state == IDLE) && !start_pend && !bus.start_req;
   assign accept   = |arb_ready;

   udc_rr_arb2 u_arb (
      .clk   (clk),
      .reset (reset),
      .valid ({bus.req1_valid, bus.req0_valid}),
      .en    (arb_en),
      .ready (arb_ready),
      .grant (arb_grant)
   );

   assign bus.req0_ready = arb_ready[0];
   assign bus.req1_ready = arb_ready[1];

   // Select the granted requester's fields for latching.
   always_comb begin
      req_sel = '0;
      if (arb_grant) begin
         req_sel.wr    = bus.req1_wr;
         req_sel.addr  = bus.req1_addr;
         req_sel.wdata = UDC_DATA_W'(bus.req1_wdata);
      end else begin
         req_sel.wr    = bus.req0_wr;
         req_sel.addr  = bus.req0_addr;
         req_sel.wdata = UDC_DATA_W'(bus.req0_wdata);
      end
   end

   // State and phase counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   // Phase sequencing; each phase loads its length minus one and counts to zero.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      case (state)
         IDLE: begin
            if (go_start) begin
               state_nx = START;
               cnt_nx   = CNT_W'(START_W - 1);
            end else if (accept) begin
               state_nx = SETUP;
               cnt_nx   = CNT_W'(SETUP_CYC - 1);
            end
         end
         SETUP: begin
            if (cnt == '0) begin
               state_nx = STROBE;
               cnt_nx   = CNT_W'(STROBE_CYC - 1);
            end else cnt_nx = cnt - CNT_W'(1);
         end
         STROBE: begin
            if (cnt == '0) begin
               state_nx = HOLD;
               cnt_nx   = CNT_W'(HOLD_CYC - 1);
            end else cnt_nx = cnt - CNT_W'(1);
         end
         HOLD: begin
            if (cnt == '0) state_nx = IDLE;
            else           cnt_nx   = cnt - CNT_W'(1);
         end
         START: begin
            if (cnt == '0) state_nx = IDLE;
            else           cnt_nx   = cnt - CNT_W'(1);
         end
         default: state_nx = IDLE;
      endcase
   end

   // Start requests merge while pending; entering START consumes the pending one.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)              start_pend <= 1'b0;
      else if (go_start)      start_pend <= 1'b0;
      else if (bus.start_req) start_pend <= 1'b1;
   end

   // Latch the accepted transaction; reads drive zero onto din.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lat    <= '0;
         lat_id <= 1'b0;
      end else if (accept) begin
         lat.wr    <= req_sel.wr;
         lat.addr  <= req_sel.addr;
         lat.wdata <= req_sel.wr ? req_sel.wdata : '0;
         lat_id    <= arb_grant;
      end
   end

   // Capture read data at the edge ending the last strobe cycle; the response
   // pulse therefore lands in the first HOLD cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         rsp_valid_q <= 1'b0;
         if (state == STROBE && cnt == '0) begin
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= lat_id;
            rsp_rdata_q <= lat.wr ? '0 : bus.bus_rdata;
         end
      end
   end

   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_rdata = rsp_rdata_q;

   // Strobes decode straight from the state register so reset releases them at once.
   assign bus.ncs      = !(state == SETUP || state == STROBE || state == HOLD);
   assign bus.nwr      = !(state == STROBE && lat.wr);
   assign bus.nrd      = !(state == STROBE && !lat.wr);
   assign bus.A0       = lat.addr[0];
   assign bus.A1       = lat.addr[1];
   assign bus.din      = DATA_W'(lat.wdata);
   assign bus.start_in = (state == START);

endmodule

// File: tb/tb_udc_bus_sequencer.sv
// Directed bench for udc_bus_sequencer: default-timing instance plus a
// stretched-timing instance for the parameter case.
module tb_udc_bus_sequencer;
   import udc_pkg::*;

   logic clk;
   logic reset;
   int   n_chk;
   int   n_fail;

   udc_bus_sequencer_if #(.DATA_W(8)) b  ();
   udc_bus_sequencer_if #(.DATA_W(8)) b2 ();

   udc_bus_sequencer u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (b)
   );

   udc_bus_sequencer #(
      .SETUP_CYC  (2),
      .STROBE_CYC (3),
      .HOLD_CYC   (2)
   ) u_dut2 (
      .clk   (clk),
      .reset (reset),
      .bus   (b2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      reset  = 1'b0;
      b.req0_valid = 0; b.req0_wr = 0; b.req0_addr = 0; b.req0_wdata = 0;
      b.req1_valid = 0; b.req1_wr = 0; b.req1_addr = 0; b.req1_wdata = 0;
      b.start_req  = 0; b.bus_rdata = 0;
      b2.req0_valid = 0; b2.req0_wr = 0; b2.req0_addr = 0; b2.req0_wdata = 0;
      b2.req1_valid = 0; b2.req1_wr = 0; b2.req1_addr = 0; b2.req1_wdata = 0;
      b2.start_req  = 0; b2.bus_rdata = 0;

      // Reset values
      #1 reset = 1'b1;
      #1;
      chk("rst_ncs", b.ncs, 1);
      chk("rst_nrd", b.nrd, 1);
      chk("rst_nwr", b.nwr, 1);
      chk("rst_addr", {b.A1, b.A0}, 0);
      chk("rst_din", b.din, 0);
      chk("rst_start_in", b.start_in, 0);
      chk("rst_rsp", {b.rsp_valid, b.rsp_id, b.rsp_rdata}, 0);
      chk("rst_ready", {b.req1_ready, b.req0_ready}, 0);
      tick(); tick();
      reset = 1'b0;

      // Write: req0 addr 2 data 5A
      b.req0_valid = 1; b.req0_wr = 1; b.req0_addr = ADDR_STAT; b.req0_wdata = 8'h5A;
      #1;
      chk("wr_ready", {b.req1_ready, b.req0_ready}, 2'b01);
      tick();
      b.req0_valid = 0;
      for (int i = 1; i <= 5; i++) begin
         chk($sformatf("wr_ncs_%0d", i), b.ncs, (i <= 4) ? 0 : 1);
         chk($sformatf("wr_nwr_%0d", i), b.nwr, (i == 2 || i == 3) ? 0 : 1);
         chk($sformatf("wr_nrd_%0d", i), b.nrd, 1);
         chk($sformatf("wr_rspv_%0d", i), b.rsp_valid, (i == 4) ? 1 : 0);
         chk($sformatf("wr_addr_%0d", i), {b.A1, b.A0}, 2'b10);
         chk($sformatf("wr_din_%0d", i), b.din, 8'h5A);
         if (i == 4) chk("wr_rsp", {b.rsp_id, b.rsp_rdata}, 9'h000);
         if (i < 5) tick();
      end

      // Read: req1 addr 3, counter returns 3C
      b.req1_valid = 1; b.req1_wr = 0; b.req1_addr = ADDR_CNT; b.bus_rdata = 8'h3C;
      #1;
      chk("rd_ready", {b.req1_ready, b.req0_ready}, 2'b10);
      tick();
      b.req1_valid = 0;
      for (int i = 1; i <= 5; i++) begin
         chk($sformatf("rd_ncs_%0d", i), b.ncs, (i <= 4) ? 0 : 1);
         chk($sformatf("rd_nrd_%0d", i), b.nrd, (i == 2 || i == 3) ? 0 : 1);
         chk($sformatf("rd_nwr_%0d", i), b.nwr, 1);
         chk($sformatf("rd_rspv_%0d", i), b.rsp_valid, (i == 4) ? 1 : 0);
         if (i == 1) chk("rd_din", b.din, 0);
         if (i == 1) chk("rd_addr", {b.A1, b.A0}, 2'b11);
         if (i == 4) chk("rd_rsp", {b.rsp_id, b.rsp_rdata}, 9'h13C);
         if (i < 5) tick();
      end

      // Contention: both valid for four transactions, grants alternate 0,1,0,1
      b.req0_valid = 1; b.req0_wr = 1; b.req0_addr = ADDR_LOAD; b.req0_wdata = 8'h11;
      b.req1_valid = 1; b.req1_wr = 1; b.req1_addr = ADDR_CTRL; b.req1_wdata = 8'h22;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk($sformatf("ctn_ready_%0d", k), {b.req1_ready, b.req0_ready},
             (k % 2 == 0) ? 2'b01 : 2'b10);
         for (int i = 1; i <= 4; i++) begin
            tick();
            chk($sformatf("ctn_busy_%0d_%0d", k, i), {b.req1_ready, b.req0_ready}, 0);
         end
         chk($sformatf("ctn_din_%0d", k), b.din, (k % 2 == 0) ? 8'h11 : 8'h22);
         chk($sformatf("ctn_rsp_%0d", k), {b.rsp_valid, b.rsp_id}, (k % 2 == 0) ? 2'b10 : 2'b11);
         tick();
      end
      b.req0_valid = 0; b.req1_valid = 0;

      // Start beats a simultaneous request
      b.start_req = 1;
      b.req0_valid = 1; b.req0_wr = 0; b.req0_addr = ADDR_STAT;
      #1;
      chk("st_ready_blocked", b.req0_ready, 0);
      tick();
      b.start_req = 0;
      chk("st_pulse1", {b.start_in, b.ncs, b.req0_ready}, 3'b110);
      tick();
      chk("st_pulse2", {b.start_in, b.ncs, b.req0_ready}, 3'b110);
      tick();
      chk("st_after", {b.start_in, b.req0_ready}, 2'b01);
      tick();
      b.req0_valid = 0;
      chk("st_req_run", {b.ncs, b.A1, b.A0}, 3'b010);
      tick(); tick(); tick(); tick();

      // Start request during START gives exactly one more pulse
      b.start_req = 1;
      tick();
      chk("mrg_p1", b.start_in, 1);
      tick();
      b.start_req = 0;
      chk("mrg_p2", b.start_in, 1);
      tick();
      chk("mrg_gap", b.start_in, 0);
      tick();
      chk("mrg_p3", b.start_in, 1);
      tick();
      chk("mrg_p4", b.start_in, 1);
      tick();
      chk("mrg_end", {b.start_in, b.ncs}, 2'b01);
      tick();
      chk("mrg_no_more", b.start_in, 0);

      // Reset during the strobe of a write
      b.req0_valid = 1; b.req0_wr = 1; b.req0_addr = ADDR_CNT; b.req0_wdata = 8'hC3;
      #1;
      chk("rm_ready", b.req0_ready, 1);
      tick();
      b.req0_valid = 0;
      tick();
      chk("rm_nwr_low", b.nwr, 0);
      reset = 1'b1;
      #1;
      chk("rm_async", {b.ncs, b.nrd, b.nwr}, 3'b111);
      chk("rm_rspv", b.rsp_valid, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("rm_no_rsp_%0d", i), b.rsp_valid, 0);
      end
      reset = 1'b0;
      b.req0_valid = 1; b.req0_wr = 0; b.req0_addr = ADDR_LOAD;
      b.req1_valid = 1; b.req1_wr = 0; b.req1_addr = ADDR_LOAD;
      #1;
      chk("rm_grant0", {b.req1_ready, b.req0_ready}, 2'b01);
      tick();
      b.req0_valid = 0; b.req1_valid = 0;
      chk("rm_after_accept", b.ncs, 0);
      tick(); tick(); tick();
      chk("rm_rsp_post", {b.rsp_valid, b.rsp_id}, 2'b10);
      tick();

      // Stretched timing on the second instance: read
      b2.req0_valid = 1; b2.req0_wr = 0; b2.req0_addr = ADDR_CTRL; b2.bus_rdata = 8'hA7;
      #1;
      chk("p_ready", b2.req0_ready, 1);
      tick();
      b2.req0_valid = 0;
      for (int i = 1; i <= 8; i++) begin
         chk($sformatf("p_ncs_%0d", i), b2.ncs, (i <= 7) ? 0 : 1);
         chk($sformatf("p_nrd_%0d", i), b2.nrd, (i >= 3 && i <= 5) ? 0 : 1);
         chk($sformatf("p_nwr_%0d", i), b2.nwr, 1);
         chk($sformatf("p_rspv_%0d", i), b2.rsp_valid, (i == 6) ? 1 : 0);
         if (i == 6) chk("p_rsp", {b2.rsp_id, b2.rsp_rdata}, 9'h0A7);
         if (i < 8) tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/udc_bus_sequencer.md
Name: udc_bus_sequencer

Overview:
- Controller in front of the `updown` counter's chip-select bus.
- Arbitrates two requesters: req0 (host) and req1 (self-test/config engine).
- Converts each granted transaction into timed ncs/nrd/nwr/A0/A1/din strobes and returns a response.
- Also generates the counter's `start_in` pulse on request.
- Sits between the test/host logic and the `updown` DUT, in the same clock domain.

Parameters:
DATA_W, 8, width of counter data bus (din) and read data
SETUP_CYC, 1, cycles ncs/address/data valid before the strobe falls (>=1)
STROBE_CYC, 2, cycles nrd/nwr held low (>=1)
HOLD_CYC, 1, cycles ncs/address/data held after the strobe rises (>=1)
START_W, 2, width in cycles of the start_in pulse (>=1)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
req0_valid  in  1  requester 0 has a transaction
req0_ready  out  1  requester 0 transaction accepted this cycle
req0_wr  in  1  1=write, 0=read
req0_addr  in  2  register address {A1,A0}
req0_wdata  in  DATA_W  write data
req1_valid / req1_ready / req1_wr / req1_addr / req1_wdata  same as req0, for requester 1
start_req  in  1  one-cycle request to pulse start_in
rsp_valid  out  1  one-cycle completion pulse
rsp_id  out  1  requester that owned the completed transaction
rsp_rdata  out  DATA_W  read data (0 for writes)
bus_rdata  in  DATA_W  read data returned by the counter during nrd low
ncs  out  1  chip select, active low
nrd  out  1  read strobe, active low
nwr  out  1  write strobe, active low
A0, A1  out  1 each  address bits
din  out  DATA_W  write data to counter
start_in  out  1  counter start pulse, active high

Behaviour:
- Reset values (immediate, asynchronous): ncs=1, nrd=1, nwr=1, A0=A1=0, din=0, start_in=0, rsp_valid=0, rsp_id=0, rsp_rdata=0, req*_ready=0, FSM=IDLE, rr_last=1 (so req0 wins first), start_pend=0.
- Reset mid-transaction aborts the transaction. No rsp_valid is issued for it.
- FSM states and transitions:
  - IDLE: highest priority is start_pend, which goes to START. Otherwise, if any request is valid, go to SETUP.
  - SETUP lasts SETUP_CYC cycles, then STROBE.
  - STROBE lasts STROBE_CYC cycles, then HOLD.
  - HOLD lasts HOLD_CYC cycles, then IDLE.
  - START lasts START_W cycles, then IDLE.
  - A single down-counter sized for the largest parameter times every phase.
- Arbitration: round-robin between requesters.
  - reqN_ready is combinational: state==IDLE & !start_pend & grant==N.
  - grant = the valid requester that is not rr_last. If only one requester is valid, it gets the grant.
  - rr_last updates to the granted id on accept.
  - At most one ready is high per cycle. A requester must hold valid and fields stable until ready.
- Accept at cycle T: id, wr, addr and wdata are latched.
  - SETUP (T+1 .. T+SETUP_CYC): ncs=0; {A1,A0}=addr; din=wdata for writes, 0 for reads.
  - STROBE: nwr=0 for writes, nrd=0 for reads.
  - HOLD: strobes back to 1; ncs, address and din unchanged.
  - Return to IDLE: ncs=1. A0, A1 and din keep their last value.
- Read data: bus_rdata is registered on the clock edge ending the last STROBE cycle.
- Response: rsp_valid pulses in the first HOLD cycle with the latched id and rsp_rdata (0 for writes).
- Throughput: with defaults, accept at T gives rsp at T+4 and IDLE at T+5; the next accept can occur at T+5. There is no back-to-back pipelining.
- start_req sets start_pend in any state. start_pend clears on entering START.
  - start_in=1 for exactly START_W cycles; ncs stays 1 throughout.
  - start_req while already pending, or while in START, is merged: it yields one further pulse at most if it arrives during START.
- Simultaneous start_req and request valid in IDLE: START is taken first; the request waits.
- nrd and nwr are never low at the same time. Neither is ever low while ncs=1.

Decomposition:
- Package `udc_pkg`:
  - enum seq_state_t {IDLE, SETUP, STROBE, HOLD, START}
  - typedef req_t struct {wr, addr[1:0], wdata}
  - localparams for address map: ADDR_LOAD=0, ADDR_CTRL=1, ADDR_STAT=2, ADDR_CNT=3
- One sub-module: `udc_rr_arb2`, the 2-way round-robin arbiter (valid[1:0], accept, rr_last → grant, ready).

Test Plan:
- Write, defaults. req0 write addr=2, wdata=0x5A accepted at T → ncs=0 T+1..T+4; nwr=0 T+2..T+3; {A1,A0}=2'b10; din=0x5A; rsp_valid at T+4 with rsp_id=0 and rsp_rdata=0; ncs=1 at T+5.
- Read. req1 read addr=3 with bus_rdata=0x3C during STROBE → nrd=0 for 2 cycles, nwr stays 1; rsp_valid with rsp_id=1 and rsp_rdata=0x3C.
- Contention. req0 and req1 both valid continuously for 4 transactions → grants alternate 0,1,0,1; exactly one ready per accept; accepts spaced 5 cycles apart.
- Start priority. start_req pulse in the same cycle req0_valid rises in IDLE → start_in=1 for 2 cycles with ncs=1; req0 accepted the cycle after START exits.
- Reset mid-transaction. Assert reset during STROBE of a write → nwr, ncs and nrd return to 1 without waiting for a clock edge; no rsp_valid; after release, req0 is granted first.
- Parameters. Set SETUP_CYC=2, STROBE_CYC=3, HOLD_CYC=2, then read → nrd low for 3 cycles; accept-to-rsp = 6 cycles; ncs low for 7 cycles.
